// File: rtl/terminal_pkg.sv
// Shared constants for the terminal video-memory writer.
// Combinational-only content: geometry defaults, key/ASCII codes, FSM encoding.
// No flow control lives here.
package terminal_pkg;

    localparam int COLS_DEF = 70;
    localparam int ROWS_DEF = 30;
    localparam int AW_DEF   = 13;

    // E0-prefixed PS/2 arrow-key scan codes
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;

    localparam logic [7:0] ASC_BS    = 8'h08;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_SPACE = 8'h20;

    localparam logic [1:0] ST_CLR_ALL = 2'd0;
    localparam logic [1:0] ST_IDLE    = 2'd1;
    localparam logic [1:0] ST_CLR_ROW = 2'd2;

endpackage

// File: rtl/vm_cell_addr.sv
// Maps (top_row, screen row, column) to a physical character-RAM address.
// Purely combinational, zero latency.
// No backpressure; shared by the char path and the row-clear path.
module vm_cell_addr
    import terminal_pkg::*;
#(
    parameter int COLS = COLS_DEF,
    parameter int ROWS = ROWS_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic [4:0]    i_top_row,
    input  logic [4:0]    i_row,
    input  logic [6:0]    i_col,
    output logic [AW-1:0] o_addr
);

    logic [5:0] w_sum;
    logic [4:0] w_prow;

    // Both operands are below ROWS, so one conditional subtract is a full mod.
    assign w_sum  = {1'b0, i_top_row} + {1'b0, i_row};
    assign w_prow = (w_sum >= 6'(ROWS)) ? 5'(w_sum - 6'(ROWS)) : w_sum[4:0];
    assign o_addr = AW'(w_prow) * AW'(COLS) + AW'(i_col);

endmodule

// File: rtl/terminal_vm_writer.sv
// Character video-memory writer: cursor, scroll origin and RAM write port.
// Accepted char -> registered RAM write one cycle later; cursor updates with it.
// char_ready is low during full-screen clear and during the row clear after a scroll.
module terminal_vm_writer
    import terminal_pkg::*;
#(
    parameter int COLS = COLS_DEF,
    parameter int ROWS = ROWS_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          char_valid,
    input  logic [7:0]    char_data,
    output logic          char_ready,
    input  logic          dir_valid,
    input  logic [7:0]    dir_code,
    output logic          vm_we,
    output logic [AW-1:0] vm_waddr,
    output logic [7:0]    vm_wdata,
    output logic [AW-1:0] roll_cnt,
    output logic [6:0]    cursor_x,
    output logic [4:0]    cursor_y
);

    localparam logic [6:0]    LAST_COL  = 7'(COLS - 1);
    localparam logic [4:0]    LAST_ROW  = 5'(ROWS - 1);
    localparam logic [AW-1:0] CELLS     = AW'(ROWS * COLS);
    localparam logic [AW-1:0] COLS_A    = AW'(COLS);
    localparam logic [AW-1:0] ROLL_LAST = AW'((ROWS - 1) * COLS);

    logic [1:0]    r_state;
    logic [AW-1:0] r_cnt;
    logic [6:0]    r_cx;
    logic [4:0]    r_cy;
    logic [4:0]    r_top;
    logic [AW-1:0] r_roll;
    logic          r_we;
    logic [AW-1:0] r_waddr;
    logic [7:0]    r_wdata;

    logic          w_acc;
    logic          w_print;
    logic          w_nl;
    logic          w_bs;
    logic          w_eol;
    logic          w_bot;
    logic          w_adv;
    logic [4:0]    w_a_row;
    logic [6:0]    w_a_col;
    logic [AW-1:0] w_addr;

    assign char_ready = (r_state == ST_IDLE);
    assign w_acc      = char_valid && char_ready;
    assign w_print    = (char_data >= 8'h20) && (char_data <= 8'h7E);
    assign w_nl       = (char_data == ASC_CR) || (char_data == ASC_LF);
    assign w_bs       = (char_data == ASC_BS);
    assign w_eol      = (r_cx == LAST_COL);
    assign w_bot      = (r_cy == LAST_ROW);
    assign w_adv      = w_nl || (w_print && w_eol);

    // Pick the cell for the address unit. A newline that scrolls clears the
    // first cell of the new bottom row on the accepting edge; that row is the
    // old top row, i.e. screen row 0 under the pre-scroll origin.
    always_comb begin
        w_a_row = r_cy;
        w_a_col = r_cx;
        if (r_state == ST_CLR_ROW) begin
            w_a_row = LAST_ROW;
            w_a_col = r_cnt[6:0];
        end else if (w_nl) begin
            w_a_row = 5'd0;
            w_a_col = 7'd0;
        end else if (w_bs) begin
            w_a_col = r_cx - 7'd1;
        end
    end

    vm_cell_addr #(.COLS(COLS), .ROWS(ROWS), .AW(AW)) u_addr (
        .i_top_row (r_top),
        .i_row     (w_a_row),
        .i_col     (w_a_col),
        .o_addr    (w_addr)
    );

    // FSM, cursor/origin bookkeeping and the registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CLR_ALL;
            r_cnt   <= '0;
            r_cx    <= '0;
            r_cy    <= '0;
            r_top   <= '0;
            r_roll  <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                ST_CLR_ALL: begin
                    if (r_cnt < CELLS) begin
                        r_we    <= 1'b1;
                        r_waddr <= r_cnt;
                        r_wdata <= ASC_SPACE;
                        r_cnt   <= r_cnt + 1'b1;
                    end else begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_CLR_ROW: begin
                    if (r_cnt < COLS_A) begin
                        r_we    <= 1'b1;
                        r_waddr <= w_addr;
                        r_wdata <= ASC_SPACE;
                        r_cnt   <= r_cnt + 1'b1;
                    end else begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (w_acc) begin
                        if (w_print) begin
                            r_we    <= 1'b1;
                            r_waddr <= w_addr;
                            r_wdata <= char_data;
                            r_cx    <= r_cx + 7'd1;
                        end else if (w_bs && (r_cx != 7'd0)) begin
                            r_we    <= 1'b1;
                            r_waddr <= w_addr;
                            r_wdata <= ASC_SPACE;
                            r_cx    <= r_cx - 7'd1;
                        end
                        if (w_adv) begin
                            r_cx <= 7'd0;
                            if (!w_bot) begin
                                r_cy <= r_cy + 5'd1;
                            end else begin
                                r_top   <= (r_top == LAST_ROW) ? 5'd0 : r_top + 5'd1;
                                r_roll  <= (r_roll == ROLL_LAST) ? '0 : r_roll + COLS_A;
                                r_state <= ST_CLR_ROW;
                                if (w_nl) begin
                                    // No own write: start the row clear now.
                                    r_we    <= 1'b1;
                                    r_waddr <= w_addr;
                                    r_wdata <= ASC_SPACE;
                                    r_cnt   <= AW'(1);
                                end else begin
                                    r_cnt   <= '0;
                                end
                            end
                        end
                    end else if (dir_valid) begin
                        case (dir_code)
                            KEY_UP:    if (r_cy != 5'd0)    r_cy <= r_cy - 5'd1;
                            KEY_DOWN:  if (r_cy != LAST_ROW) r_cy <= r_cy + 5'd1;
                            KEY_LEFT:  if (r_cx != 7'd0)    r_cx <= r_cx - 7'd1;
                            KEY_RIGHT: if (r_cx != LAST_COL) r_cx <= r_cx + 7'd1;
                            default: ;
                        endcase
                    end
                end
                default: begin
                    r_state <= ST_CLR_ALL;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign vm_we    = r_we;
    assign vm_waddr = r_waddr;
    assign vm_wdata = r_wdata;
    assign roll_cnt = r_roll;
    assign cursor_x = r_cx;
    assign cursor_y = r_cy;

endmodule

// File: tb/tb_terminal_vm_writer.sv
// Directed bench for terminal_vm_writer: reset clear, print/backspace,
// wrap, scroll, origin wrap-around and arrow keys.
// Writes are logged on the falling edge and compared against hand values.
module tb_terminal_vm_writer;
    import terminal_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;
    logic        dir_valid;
    logic [7:0]  dir_code;
    logic        vm_we;
    logic [12:0] vm_waddr;
    logic [7:0]  vm_wdata;
    logic [12:0] roll_cnt;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;

    int n_checks = 0;
    int n_fail   = 0;
    logic [20:0] wq[$];

    terminal_vm_writer dut (
        .clk        (clk),
        .rst        (rst),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .dir_valid  (dir_valid),
        .dir_code   (dir_code),
        .vm_we      (vm_we),
        .vm_waddr   (vm_waddr),
        .vm_wdata   (vm_wdata),
        .roll_cnt   (roll_cnt),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (vm_we === 1'b1) wq.push_back({vm_waddr, vm_wdata});
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int w = 0;
        while (!char_ready && w < 300) begin
            tick(1);
            w++;
        end
        if (w >= 300) check_val("ready_timeout", 32'(char_ready), 32'd1);
    endtask

    task automatic send_char(input logic [7:0] c);
        wait_ready();
        char_valid = 1'b1;
        char_data  = c;
        tick(1);
        char_valid = 1'b0;
    endtask

    task automatic send_dir(input logic [7:0] c);
        dir_valid = 1'b1;
        dir_code  = c;
        tick(1);
        dir_valid = 1'b0;
    endtask

    task automatic expect_write(input string tag, input logic [12:0] a, input logic [7:0] d);
        logic [20:0] e;
        check_val({tag, "_present"}, 32'(wq.size() > 0), 32'd1);
        if (wq.size() > 0) begin
            e = wq.pop_front();
            check_val({tag, "_addr"}, 32'(e[20:8]), 32'(a));
            check_val({tag, "_data"}, 32'(e[7:0]), 32'(d));
        end
    endtask

    task automatic check_cursor(input string tag, input int x, input int y);
        check_val({tag, "_x"}, 32'(cursor_x), 32'(x));
        check_val({tag, "_y"}, 32'(cursor_y), 32'(y));
    endtask

    // Counts queued writes that are not "space at address base+i".
    task automatic check_space_run(input string tag, input int base, input int len);
        int bad = 0;
        logic [20:0] e;
        check_val({tag, "_count"}, 32'(wq.size()), 32'(len));
        for (int i = 0; i < wq.size(); i++) begin
            e = {13'(base + i), 8'h20};
            if (wq[i] !== e) bad++;
        end
        check_val({tag, "_bad"}, 32'(bad), 32'd0);
        wq.delete();
    endtask

    initial begin
        int cyc;
        int lowc;
        rst        = 1'b1;
        char_valid = 1'b0;
        char_data  = 8'h00;
        dir_valid  = 1'b0;
        dir_code   = 8'h00;

        // Reset and full-screen clear
        tick(2);
        check_val("rst_we", 32'(vm_we), 32'd0);
        check_val("rst_ready", 32'(char_ready), 32'd0);
        check_val("rst_roll", 32'(roll_cnt), 32'd0);
        check_cursor("rst_cursor", 0, 0);
        rst = 1'b0;
        wq.delete();
        cyc = 0;
        while (!char_ready && cyc < 3000) begin
            tick(1);
            cyc++;
        end
        check_val("clr_all_ready_cycle", 32'(cyc), 32'd2101);
        check_space_run("clr_all", 0, 2100);
        check_val("post_clr_roll", 32'(roll_cnt), 32'd0);
        check_cursor("post_clr_cursor", 0, 0);

        // Print and backspace
        send_char(8'h41);
        send_char(8'h42);
        tick(2);
        expect_write("wr_A", 13'd0, 8'h41);
        expect_write("wr_B", 13'd1, 8'h42);
        check_cursor("after_AB", 2, 0);
        send_char(ASC_BS);
        tick(2);
        expect_write("bs1", 13'd1, 8'h20);
        check_cursor("after_bs1", 1, 0);
        send_char(ASC_BS);
        tick(2);
        expect_write("bs2", 13'd0, 8'h20);
        send_char(ASC_BS);
        tick(3);
        check_val("bs_at_0_nowrite", 32'(wq.size()), 32'd0);
        check_cursor("bs_at_0", 0, 0);

        // Arrow keys
        send_dir(KEY_LEFT);
        check_cursor("dir_left_clamp", 0, 0);
        send_dir(KEY_UP);
        check_cursor("dir_up_clamp", 0, 0);
        send_dir(KEY_RIGHT);
        tick(2);
        check_cursor("dir_right", 1, 0);
        check_val("dir_nowrite", 32'(wq.size()), 32'd0);
        send_dir(KEY_DOWN);
        check_cursor("dir_down", 1, 1);
        send_dir(KEY_UP);
        check_cursor("dir_up", 1, 0);
        send_dir(8'h11);
        check_cursor("dir_unknown", 1, 0);
        char_valid = 1'b1;
        char_data  = 8'h5A;
        dir_valid  = 1'b1;
        dir_code   = KEY_RIGHT;
        tick(1);
        char_valid = 1'b0;
        dir_valid  = 1'b0;
        tick(2);
        expect_write("char_vs_dir", 13'd1, 8'h5A);
        check_cursor("char_vs_dir", 2, 0);
        send_dir(KEY_LEFT);
        send_dir(KEY_LEFT);
        check_cursor("dir_back_home", 0, 0);

        // Line wrap
        for (int i = 0; i < 70; i++) send_char(8'h43);
        tick(2);
        check_val("wrap_count", 32'(wq.size()), 32'd70);
        if (wq.size() == 70) check_val("wrap_last_addr", 32'(wq[69][20:8]), 32'd69);
        check_cursor("wrap_cursor", 0, 1);
        wq.delete();
        send_char(8'h44);
        tick(2);
        expect_write("after_wrap", 13'd70, 8'h44);

        // Move to (5,29) and scroll
        for (int i = 0; i < 28; i++) send_char(ASC_CR);
        for (int i = 0; i < 5; i++) send_char(8'h45);
        tick(2);
        check_cursor("pre_scroll", 5, 29);
        check_val("pre_scroll_roll", 32'(roll_cnt), 32'd0);
        wq.delete();
        send_char(ASC_CR);
        check_val("scroll_roll", 32'(roll_cnt), 32'd70);
        lowc = 0;
        while (!char_ready && lowc < 200) begin
            if (lowc == 10) begin
                dir_valid = 1'b1;
                dir_code  = KEY_UP;
            end
            tick(1);
            dir_valid = 1'b0;
            lowc++;
        end
        check_val("scroll_stall", 32'(lowc), 32'd70);
        check_cursor("scroll_cursor", 0, 29);
        check_space_run("clr_row", 0, 70);
        send_char(8'h58);
        tick(2);
        expect_write("after_scroll", 13'd0, 8'h58);

        // Origin wrap-around
        for (int i = 0; i < 28; i++) send_char(ASC_CR);
        wait_ready();
        check_val("roll_top29", 32'(roll_cnt), 32'd2030);
        for (int i = 0; i < 28; i++) send_dir(KEY_UP);
        check_cursor("top29_cursor", 0, 1);
        wq.delete();
        send_char(8'h59);
        tick(2);
        expect_write("top29_row1", 13'd0, 8'h59);
        for (int i = 0; i < 28; i++) send_dir(KEY_DOWN);
        check_cursor("before_last_scroll", 1, 29);
        send_char(ASC_LF);
        check_val("roll_wrap", 32'(roll_cnt), 32'd0);
        wait_ready();
        check_space_run("clr_row_wrap", 2030, 70);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
